// File: rtl/fifo_drain_display_pkg.sv
// Shared definitions for the FIFO drain/display block: FSM state encoding
// and the hex-digit to active-low seven-segment table ({g,f,e,d,c,b,a}).
package fifo_drain_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int SEG_W = 7;

  // Index is the hex digit value; a bit is 0 when its segment is lit.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/fifo_drain_display_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import fifo_drain_display_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/fifo_drain_display.sv
// Pops one byte at a time from a FIFO read port, shows it on LEDs and two
// seven-segment digits for HOLD_CYCLES clocks, and counts captured bytes.
module fifo_drain_display
  import fifo_drain_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic [7:0]       data_out,
  output logic [SEG_W-1:0] seg_lo,
  output logic [SEG_W-1:0] seg_hi,
  output logic             shown,
  output logic [7:0]       pop_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic [7:0]       r_pop_cnt;
  logic             w_hold_done;

  assign w_hold_done = (r_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_pop_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        // Read data is valid one cycle after the pop strobe.
        S_WAIT: begin
          r_data    <= fifo_dout;
          r_pop_cnt <= r_pop_cnt + 8'd1;
          r_cnt     <= '0;
        end
        S_HOLD:  r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    fifo_rd_en = 1'b0;
    shown      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && !fifo_empty) w_next = S_POP;
      end
      S_POP: begin
        fifo_rd_en = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: w_next = S_HOLD;
      S_HOLD: begin
        shown = 1'b1;
        if (w_hold_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign data_out = r_data;
  assign pop_cnt  = r_pop_cnt;

  hex7seg u_seg_lo (
    .i_nib (r_data[3:0]),
    .o_seg (seg_lo)
  );

  hex7seg u_seg_hi (
    .i_nib (r_data[7:4]),
    .o_seg (seg_hi)
  );

endmodule

// File: tb/tb_fifo_drain_display.sv
// Directed bench for fifo_drain_display with a behavioural FIFO read side
// and a queue of expected captured bytes.
module tb_fifo_drain_display;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic [7:0] data_out;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;
  logic       shown;
  logic [7:0] pop_cnt;

  fifo_drain_display #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .data_out   (data_out),
    .seg_lo     (seg_lo),
    .seg_hi     (seg_hi),
    .shown      (shown),
    .pop_cnt    (pop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: the bench writes, the DUT reads.
  logic [7:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Pop-strobe monitor.
  int cyc = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  int last_rd = 0;
  int rd_gap = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt  <= rd_cnt + 1;
      rd_gap  <= cyc - last_rd;
      last_rd <= cyc;
      if (fifo_empty) rd_bad <= rd_bad + 1;
    end
  end

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
    exp_q.push_back(b);
  endtask

  task automatic wait_shown(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (shown === 1'b1) break;
      step();
    end
    check({tag, "_shown_timeout"}, shown, 1'b1);
  endtask

  task automatic check_capture(input string tag);
    logic [8:0] e;
    e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
    check({tag, "_data"}, data_out, e);
    check({tag, "_seg_lo"}, seg_lo, ref_seg(e[3:0]));
    check({tag, "_seg_hi"}, seg_hi, ref_seg(e[7:4]));
  endtask

  task automatic measure_hold(input string tag);
    int n = 0;
    while (shown === 1'b1 && n < 60) begin
      n++;
      step();
    end
    check({tag, "_hold_len"}, n, HOLD);
  endtask

  initial begin
    int rd0;
    rst = 1'b1;
    en  = 1'b1;
    push(8'hA5);

    // Reset held two cycles with FIFO non-empty and enable high.
    step();
    step();
    check("rst_rd_cnt", rd_cnt, 0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_pop_cnt", pop_cnt, 8'd0);
    check("rst_shown", shown, 1'b0);
    check("rst_seg_lo", seg_lo, 7'b1000000);
    check("rst_seg_hi", seg_hi, 7'b1000000);

    // Single byte A5: exact latency.
    rst = 1'b0;
    step();
    check("single_rd_en_pop", fifo_rd_en, 1'b1);
    step();
    check("single_rd_en_wait", fifo_rd_en, 1'b0);
    check("single_shown_wait", shown, 1'b0);
    step();
    check("single_shown", shown, 1'b1);
    check_capture("single");
    check("single_pop_cnt", pop_cnt, 8'd1);
    measure_hold("single");
    check("single_rd_cnt", rd_cnt, 1);
    check("single_idle_data", data_out, 8'hA5);

    // Burst of three bytes back to back.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int k = 0; k < 3; k++) begin
      wait_shown("burst");
      check_capture("burst");
      if (k > 0) check("burst_rd_gap", rd_gap, HOLD + 3);
      measure_hold("burst");
    end
    repeat (10) step();
    check("burst_empty", fifo_empty, 1'b1);
    check("burst_rd_cnt", rd_cnt, 4);
    check("burst_pop_cnt", pop_cnt, 8'd4);

    // Enable dropped during hold of 3C while 55 is still queued.
    push(8'h3C);
    push(8'h55);
    wait_shown("endrop");
    check_capture("endrop");
    en = 1'b0;
    measure_hold("endrop");
    rd0 = rd_cnt;
    repeat (10) step();
    check("endrop_no_pop", rd_cnt, rd0);
    check("endrop_retain", data_out, 8'h3C);
    check("endrop_shown_idle", shown, 1'b0);
    check("endrop_not_empty", fifo_empty, 1'b0);
    en = 1'b1;
    step();
    step();
    check("endrop_repop", rd_cnt, rd0 + 1);
    wait_shown("endrop2");
    check_capture("endrop2");
    measure_hold("endrop2");

    // Reset pulsed in WAIT: the in-flight byte is lost.
    push(8'h11);
    push(8'h22);
    for (int i = 0; i < 20 && fifo_rd_en !== 1'b1; i++) step();
    check("midrst_rd_en", fifo_rd_en, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_front());
    check("midrst_pop_cnt", pop_cnt, 8'd0);
    check("midrst_data", data_out, 8'h00);
    check("midrst_shown", shown, 1'b0);
    wait_shown("midrst");
    check_capture("midrst");
    check("midrst_pop_cnt1", pop_cnt, 8'd1);
    measure_hold("midrst");

    // Counter wrap: 257 bytes after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wrap_rst_cnt", pop_cnt, 8'd0);
    for (int i = 0; i < 257; i++) push(8'(i * 7 + 3));
    for (int i = 0; i < 257; i++) begin
      wait_shown("wrap");
      check_capture("wrap");
      measure_hold("wrap");
    end
    rd0 = rd_cnt;
    repeat (20) step();
    check("wrap_pop_cnt", pop_cnt, 8'd1);
    check("wrap_no_pop_empty", rd_cnt, rd0);
    check("rd_while_empty", rd_bad, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
